os_systolic_array_v2: RTL
=========================

Name: os_systolic_array_v2

Overview:
- Parametrised output-stationary ROWS x COLS int8 systolic matrix-multiply engine, C[ROWS][COLS] = A[ROWS][K] x W[K][COLS], with K programmable per job up to K_MAX.
- Owns the operand skewing, bias add, requantisation shift, optional ReLU, saturation, and a valid/ready result drain.
- Replaces the fixed 8x8 array in the accelerator datapath, sitting between the operand buffers and the activation writeback.

Parameters:
- DATA_WIDTH, 8, signed width of activations, weights, bias and outputs
- ROWS, 8, array rows (m); also the number of output beats
- COLS, 8, array columns (n); also the number of elements per output beat
- K_MAX, 64, maximum inner dimension (l) per job
- ACC_WIDTH, 22, signed accumulator width; must be >= 2*DATA_WIDTH + clog2(K_MAX)
- SHW, 5, width of shift_i

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- start_i  in  1  job start pulse; accepted only in IDLE
- k_len_i  in  clog2(K_MAX+1)  inner length K, latched on start
- shift_i  in  SHW  arithmetic right-shift amount, latched on start
- relu_en_i  in  1  ReLU enable, latched on start
- bias_valid_i  in  1  bias vector valid
- bias_i  in  COLS*DATA_WIDTH  per-output-column bias, signed
- bias_ready_o  out  1  high in BIAS state
- a_valid_i  in  1  operand beat valid
- a_col_i  in  ROWS*DATA_WIDTH  column k of A, unskewed; lane r = A[r][k]
- w_row_i  in  COLS*DATA_WIDTH  row k of W, unskewed; lane c = W[k][c]
- a_ready_o  out  1  high in FEED state
- out_valid_o  out  1  result row valid
- out_ready_i  in  1  result row accepted
- out_row_o  in/out: out  COLS*DATA_WIDTH  result row r; lane c = C[r][c]
- out_last_o  out  1  high with the final row (r = ROWS-1)
- busy_o  out  1  high whenever state != IDLE
- done_o  out  1  one-cycle pulse after the last row handshake

Behaviour:
- Reset: state IDLE; all accumulators, skew registers and bias registers cleared. All outputs are 0 (out_row_o = 0).
- FSM:
  - IDLE -> BIAS on start_i.
  - BIAS -> FEED on a bias handshake. If k_len = 0, BIAS -> POST instead.
  - FEED accepts exactly k_len beats, then -> FLUSH.
  - FLUSH lasts ROWS+COLS-1 cycles, then -> POST.
  - POST lasts 1 cycle, then -> DRAIN.
  - DRAIN emits ROWS rows, then -> IDLE with done_o pulsed in the cycle after.
- Clear: accumulators clear on the cycle start_i is accepted.
- Skew: lane r of A is delayed r cycles and lane c of W is delayed c cycles. Each datum carries a valid tag. PE(r,c) accumulates product A*W (signed, full precision) only when both tags are set.
- Stalls: a beat with a_valid_i=0 in FEED injects zero and tag 0. Stalls therefore never corrupt results.
- FLUSH injects tag-0 zeros. Its length guarantees the last product reaches PE(ROWS-1,COLS-1).
- POST, per PE:
  - s = (acc + (sext(bias[c]) <<< shift)) >>> shift, arithmetic.
  - If relu, s = max(s, 0).
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Result is registered into the PE's result register.
- DRAIN:
  - out_valid_o is high. out_row_o carries row index r, starting at 0.
  - r advances only on out_valid_o & out_ready_i.
  - While out_ready_i is low, out_row_o and out_last_o hold stable.
- Ignored inputs: start_i while busy; bias_valid_i outside BIAS; a_valid_i outside FEED. No state change for any of these.
- Zero-K job: a zero-K job yields sat(relu(bias)) in every row.
- Reset mid-job: reset returns to IDLE immediately. No done_o is produced and no out_valid_o is asserted.
- Latency (no stalls, immediate bias, out_ready_i=1):
  - start to first out_valid_o = 1 + 1 + K + (ROWS+COLS-1) + 1 cycles.
  - Default 8x8, K=8: 26 cycles. The drain then takes ROWS cycles.
- Accumulator width is sized so no overflow is possible for K <= K_MAX. k_len_i > K_MAX is clamped to K_MAX.

Test Plan:
- Ones: K=8, A=1, W=1, bias=0, shift=0, relu=0 -> 8 rows of all 8. First valid 26 cycles after start. out_last_o on row 7, then done_o.
- Shift/bias: K=2, A=16, W=16, shift=7, bias=0 -> every element 4. Repeat with bias=3 -> every element 7.
- Sign/ReLU/saturation:
  - K=4, A=-1, W=1, bias=0 -> -4 with relu=0; 0 with relu=1.
  - K=64, A=127, W=127, shift=0 -> 127.
  - K=64, A=-128, W=127 -> -128.
- Distinct values: A[r][k]=r+1, W[k][c]=c+1, K=3 -> C[r][c] = 3(r+1)(c+1); row 7 = 24,48,...,192 saturated to 127 from c=5. With a_valid_i toggling every other cycle -> identical results, FEED takes 6 cycles.
- Backpressure/ignore:
  - out_ready_i low for 5 cycles at row 3 -> row 3 held, no row skipped or repeated.
  - A start_i pulse during DRAIN is ignored.
  - K=0 with bias=5 -> all 5.
- Reset mid-FEED after 3 beats -> all outputs 0, busy_o low. A following K=8 ones job gives all 8, with no residue from the aborted job.

Source files
------------

// File: rtl/os_systolic_array_v2.sv
// Output-stationary ROWS x COLS int8 systolic matmul engine with operand skew,
// bias/shift requantisation, optional ReLU, saturation and a row-wise result drain.
module os_systolic_array_v2 #(
   parameter int DATA_WIDTH = 8,
   parameter int ROWS       = 8,
   parameter int COLS       = 8,
   parameter int K_MAX      = 64,
   parameter int ACC_WIDTH  = 22,
   parameter int SHW        = 5,
   localparam int KW        = $clog2(K_MAX + 1)
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       start_i,
   input  logic [KW-1:0]              k_len_i,
   input  logic [SHW-1:0]             shift_i,
   input  logic                       relu_en_i,
   input  logic                       bias_valid_i,
   input  logic [COLS*DATA_WIDTH-1:0] bias_i,
   output logic                       bias_ready_o,
   input  logic                       a_valid_i,
   input  logic [ROWS*DATA_WIDTH-1:0] a_col_i,
   input  logic [COLS*DATA_WIDTH-1:0] w_row_i,
   output logic                       a_ready_o,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [COLS*DATA_WIDTH-1:0] out_row_o,
   output logic                       out_last_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic [2:0]                 dbg_state_o
);
   localparam int DW = DATA_WIDTH;
   localparam int CW = $clog2(K_MAX + ROWS + COLS);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int EW = ACC_WIDTH + (1 << SHW);
   localparam logic signed [EW-1:0] SAT_MAX = EW'((1 << (DW - 1)) - 1);
   localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [2:0] {S_IDLE, S_BIAS, S_FEED, S_FLUSH, S_POST, S_DRAIN} state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [RW-1:0]        row_q, row_d;
   logic                 done_q, done_d;
   logic [KW-1:0]        k_q;
   logic [SHW-1:0]       shift_q;
   logic                 relu_q;
   logic [COLS*DW-1:0]   bias_q;
   logic                 clear, feed_beat;

   // Operand words carry their valid tag in the MSB: {tag, data}.
   logic [DW:0]          a_edge [ROWS];
   logic [DW:0]          w_edge [COLS];
   logic [DW:0]          a_pe   [ROWS][COLS];
   logic [DW:0]          w_pe   [ROWS][COLS];
   logic [DW:0]          a_q    [ROWS][COLS-1];
   logic [DW:0]          w_q    [ROWS-1][COLS];
   logic [ACC_WIDTH-1:0] acc_q  [ROWS][COLS];
   logic [DW-1:0]        res_q  [ROWS][COLS];

   function automatic logic [ACC_WIDTH-1:0] prod_ext(input logic [DW-1:0] a, input logic [DW-1:0] w);
      logic signed [2*DW-1:0] p;
      p = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{w[DW-1]}}, w});
      return {{(ACC_WIDTH-2*DW){p[2*DW-1]}}, p};
   endfunction

   function automatic logic [DW-1:0] post_fn(input logic [ACC_WIDTH-1:0] acc, input logic [DW-1:0] b,
                                             input logic [SHW-1:0] sh, input logic relu);
      logic signed [EW-1:0] s;
      s = $signed({{(EW-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc}) + ($signed({{(EW-DW){b[DW-1]}}, b}) <<< sh);
      s = s >>> sh;
      if (relu && s[EW-1]) s = '0;
      if (s > SAT_MAX) s = SAT_MAX;
      else if (s < SAT_MIN) s = SAT_MIN;
      return s[DW-1:0];
   endfunction

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // ready depends only on state, and valid may be raised without waiting for ready.
   assign clear        = (state_q == S_IDLE) && start_i;
   assign feed_beat    = (state_q == S_FEED) && a_valid_i;
   assign busy_o       = (state_q != S_IDLE);
   assign bias_ready_o = (state_q == S_BIAS);
   assign a_ready_o    = (state_q == S_FEED);
   assign out_valid_o  = (state_q == S_DRAIN);
   assign out_last_o   = (state_q == S_DRAIN) && (row_q == RW'(ROWS - 1));
   assign done_o       = done_q;
   assign dbg_state_o  = state_q;

   for (genvar gr = 0; gr < ROWS; gr++) begin : g_askew
      logic [DW:0] inj;
      assign inj = feed_beat ? {1'b1, a_col_i[gr*DW +: DW]} : '0;
      if (gr == 0) begin : g_direct
         assign a_edge[gr] = inj;
      end else begin : g_delay
         logic [DW:0] sr_q [gr];
         always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
               for (int i = 0; i < gr; i++) sr_q[i] <= '0;
            end else if (clear) begin
               for (int i = 0; i < gr; i++) sr_q[i] <= '0;
            end else begin
               sr_q[0] <= inj;
               for (int i = 1; i < gr; i++) sr_q[i] <= sr_q[i-1];
            end
         end
         assign a_edge[gr] = sr_q[gr-1];
      end
   end

   for (genvar gc = 0; gc < COLS; gc++) begin : g_wskew
      logic [DW:0] inj;
      assign inj = feed_beat ? {1'b1, w_row_i[gc*DW +: DW]} : '0;
      if (gc == 0) begin : g_direct
         assign w_edge[gc] = inj;
      end else begin : g_delay
         logic [DW:0] sr_q [gc];
         always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
               for (int i = 0; i < gc; i++) sr_q[i] <= '0;
            end else if (clear) begin
               for (int i = 0; i < gc; i++) sr_q[i] <= '0;
            end else begin
               sr_q[0] <= inj;
               for (int i = 1; i < gc; i++) sr_q[i] <= sr_q[i-1];
            end
         end
         assign w_edge[gc] = sr_q[gc-1];
      end
   end

   for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
      for (genvar gc = 0; gc < COLS; gc++) begin : g_col
         if (gc == 0) begin : g_al
            assign a_pe[gr][gc] = a_edge[gr];
         end else begin : g_ai
            assign a_pe[gr][gc] = a_q[gr][gc-1];
         end
         if (gr == 0) begin : g_wt
            assign w_pe[gr][gc] = w_edge[gc];
         end else begin : g_wi
            assign w_pe[gr][gc] = w_q[gr-1][gc];
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS - 1; c++) a_q[r][c] <= '0;
         for (int r = 0; r < ROWS - 1; r++) for (int c = 0; c < COLS; c++) w_q[r][c] <= '0;
         for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) begin
            acc_q[r][c] <= '0;
            res_q[r][c] <= '0;
         end
      end else begin
         for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS - 1; c++)
            a_q[r][c] <= clear ? '0 : a_pe[r][c];
         for (int r = 0; r < ROWS - 1; r++) for (int c = 0; c < COLS; c++)
            w_q[r][c] <= clear ? '0 : w_pe[r][c];
         for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) begin
            if (clear)
               acc_q[r][c] <= '0;
            else if (a_pe[r][c][DW] && w_pe[r][c][DW])
               acc_q[r][c] <= acc_q[r][c] + prod_ext(a_pe[r][c][DW-1:0], w_pe[r][c][DW-1:0]);
            if (state_q == S_POST)
               res_q[r][c] <= post_fn(acc_q[r][c], bias_q[c*DW +: DW], shift_q, relu_q);
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         row_q   <= '0;
         done_q  <= 1'b0;
         k_q     <= '0;
         shift_q <= '0;
         relu_q  <= 1'b0;
         bias_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         done_q  <= done_d;
         if (clear) begin
            k_q     <= (k_len_i > KW'(K_MAX)) ? KW'(K_MAX) : k_len_i;
            shift_q <= shift_i;
            relu_q  <= relu_en_i;
         end
         if ((state_q == S_BIAS) && bias_valid_i) bias_q <= bias_i;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: if (start_i) begin
            state_d = S_BIAS;
            cnt_d   = '0;
            row_d   = '0;
         end
         S_BIAS: if (bias_valid_i) state_d = (k_q == '0) ? S_POST : S_FEED;
         S_FEED: if (a_valid_i) begin
            if (cnt_q == CW'(k_q) - 1'b1) begin
               state_d = S_FLUSH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         // Long enough for the last tagged product to reach PE(ROWS-1, COLS-1).
         S_FLUSH: if (cnt_q == CW'(ROWS + COLS - 2)) begin
            state_d = S_POST;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         S_POST: begin
            state_d = S_DRAIN;
            row_d   = '0;
         end
         S_DRAIN: if (out_ready_i) begin
            if (row_q == RW'(ROWS - 1)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               row_d = row_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      out_row_o = '0;
      if (state_q == S_DRAIN)
         for (int c = 0; c < COLS; c++) out_row_o[c*DW +: DW] = res_q[row_q][c];
   end
endmodule
